// File: rtl/dff_ctrl_pkg.sv
// Shared definitions for the dflip chain loader: sequencer state encoding and
// a width helper for small counters.
package dff_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter width able to hold values up to value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int bits_v;
        if (value <= 2) begin
            bits_v = 1;
        end else begin
            bits_v = $clog2(value);
        end
        return bits_v;
    endfunction

endpackage

// File: rtl/dff_down_counter.sv
// Loadable down counter with a registered zero flag; it stops at zero rather
// than wrapping.
module dff_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          zero_r;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        count_s = count_r;
        if (load) begin
            count_s = load_val;
        end else if (en && (count_r != {CW{1'b0}})) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Count register and its zero flag, updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            zero_r  <= 1'b1;
        end else begin
            count_r <= count_s;
            zero_r  <= (count_s == {CW{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/dff_chain_loader.sv
// Serial loader for an external dflip chain: takes a parallel word over
// valid/ready, shifts it out MSB-first with a gated enable, settles, pulses done.
module dff_chain_loader
    import dff_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       abort,
    output logic                       d_out,
    output logic                       shift_en,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int BCW        = $clog2(WIDTH + 1);
    localparam int SHIFT_CW   = clog2_min1(WIDTH - 1);
    localparam int SETTLE_CW  = clog2_min1(HOLD_CYCLES + 1);
    localparam bit HAS_SETTLE = (HOLD_CYCLES > 0);

    // The first bit leaves on the accept edge, so the shift counter only
    // tracks the remaining WIDTH-1 edges (zero flag marks the last one).
    localparam logic [SHIFT_CW-1:0]  SHIFT_LOAD  = SHIFT_CW'(WIDTH - 2);
    localparam logic [SETTLE_CW-1:0] SETTLE_LOAD = SETTLE_CW'(HAS_SETTLE ? HOLD_CYCLES - 1 : 0);
    localparam logic [BCW-1:0]       BIT_MAX     = BCW'(WIDTH);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_s;
    logic             d_out_r;
    logic             d_out_s;
    logic             shift_en_r;
    logic             shift_en_s;
    logic [BCW-1:0]   bit_cnt_r;
    logic [BCW-1:0]   bit_cnt_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             in_ready_r;
    logic             in_ready_s;

    logic             shift_load_s;
    logic             shift_dec_s;
    logic             shift_zero_s;
    logic             settle_load_s;
    logic             settle_dec_s;
    logic             settle_zero_s;
    logic [BCW-1:0]   bit_cnt_inc_s;

    assign bit_cnt_inc_s = (bit_cnt_r == BIT_MAX) ? BIT_MAX : (bit_cnt_r + BCW'(1));

    dff_down_counter #(
        .CW (SHIFT_CW)
    ) u_shift_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (shift_load_s),
        .en       (shift_dec_s),
        .load_val (SHIFT_LOAD),
        .zero     (shift_zero_s)
    );

    dff_down_counter #(
        .CW (SETTLE_CW)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (settle_load_s),
        .en       (settle_dec_s),
        .load_val (SETTLE_LOAD),
        .zero     (settle_zero_s)
    );

    // Next-state and next-output logic; d_out/shift_en default low so every
    // non-shifting cycle presents a quiet chain input.
    always_comb begin
        state_s       = state_r;
        shadow_s      = shadow_r;
        d_out_s       = 1'b0;
        shift_en_s    = 1'b0;
        bit_cnt_s     = bit_cnt_r;
        done_s        = 1'b0;
        shift_load_s  = 1'b0;
        shift_dec_s   = 1'b0;
        settle_load_s = 1'b0;
        settle_dec_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (in_valid && in_ready_r) begin
                    d_out_s      = load_data[WIDTH-1];
                    shadow_s     = {load_data[WIDTH-2:0], 1'b0};
                    shift_en_s   = 1'b1;
                    bit_cnt_s    = BCW'(1);
                    shift_load_s = 1'b1;
                    state_s      = S_SHIFT;
                end else begin
                    state_s      = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    bit_cnt_s = {BCW{1'b0}};
                    state_s   = S_IDLE;
                end else begin
                    d_out_s    = shadow_r[WIDTH-1];
                    shadow_s   = {shadow_r[WIDTH-2:0], 1'b0};
                    shift_en_s = 1'b1;
                    bit_cnt_s  = bit_cnt_inc_s;
                    if (shift_zero_s) begin
                        if (HAS_SETTLE) begin
                            settle_load_s = 1'b1;
                            state_s       = S_SETTLE;
                        end else begin
                            state_s       = S_DONE;
                        end
                    end else begin
                        shift_dec_s = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    bit_cnt_s = {BCW{1'b0}};
                    state_s   = S_IDLE;
                end else if (settle_zero_s) begin
                    state_s   = S_DONE;
                end else begin
                    settle_dec_s = 1'b1;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                bit_cnt_s = {BCW{1'b0}};
                state_s   = S_IDLE;
            end
        endcase

        busy_s     = (state_s != S_IDLE);
        in_ready_s = (state_s == S_IDLE);
    end

    // State, shadow word and every output are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            shadow_r   <= {WIDTH{1'b0}};
            d_out_r    <= 1'b0;
            shift_en_r <= 1'b0;
            bit_cnt_r  <= {BCW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            shadow_r   <= shadow_s;
            d_out_r    <= d_out_s;
            shift_en_r <= shift_en_s;
            bit_cnt_r  <= bit_cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            in_ready_r <= in_ready_s;
        end
    end

    assign in_ready = in_ready_r;
    assign d_out    = d_out_r;
    assign shift_en = shift_en_r;
    assign bit_cnt  = bit_cnt_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_dff_chain_loader.sv
// Bench for dff_chain_loader: a cycle-indexed load model checked every cycle,
// directed scenarios with literal expectations, and an 8-deep gated chain.
module tb_dff_chain_loader;

    localparam int W = 8;
    localparam int H = 2;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] load_data;
    logic       abort;
    logic       d_out;
    logic       shift_en;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       done;

    logic       in_valid0;
    logic       in_ready0;
    logic [7:0] load_data0;
    logic       abort0;
    logic       d_out0;
    logic       shift_en0;
    logic [3:0] bit_cnt0;
    logic       busy0;
    logic       done0;

    logic [7:0] chain;
    logic [7:0] chain0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // model: m_k = cycles since the accepting edge (-1 when idle)
    int         m_k;
    logic [7:0] m_word;
    logic [3:0] m_idle_cnt;
    logic [8:0] exp_v;

    dff_chain_loader #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .load_data(load_data), .abort(abort), .d_out(d_out), .shift_en(shift_en),
        .bit_cnt(bit_cnt), .busy(busy), .done(done)
    );

    dff_chain_loader #(.WIDTH(W), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .load_data(load_data0), .abort(abort0), .d_out(d_out0), .shift_en(shift_en0),
        .bit_cnt(bit_cnt0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (shift_en)  chain  <= {chain[6:0], d_out};
    always @(posedge clk) if (shift_en0) chain0 <= {chain0[6:0], d_out0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // {in_ready, busy, done, shift_en, d_out, bit_cnt[3:0]} for cycle k of a load
    function automatic logic [8:0] model_out(input int k, input logic [7:0] w, input logic [3:0] idle_cnt);
        logic [8:0] v;
        if (k >= 1 && k <= W)            v = {1'b0, 1'b1, 1'b0, 1'b1, w[W-k], 4'(k)};
        else if (k > W && k <= W + H)    v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(W)};
        else if (k == W + H + 1)         v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(W)};
        else                             v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle_cnt};
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k        <= -1;
            m_idle_cnt <= 4'd0;
        end else if (m_k < 0 || m_k == W + H + 1) begin
            if (m_k == W + H + 1) m_idle_cnt <= 4'(W);
            if (in_valid) begin
                m_word <= load_data;
                m_k    <= 1;
            end else begin
                m_k    <= -1;
            end
        end else if (abort && m_k < W + H) begin
            m_k        <= -1;
            m_idle_cnt <= 4'd0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = model_out(m_k, m_word, m_idle_cnt);
            chk("m_in_ready", in_ready, exp_v[8]);
            chk("m_busy",     busy,     exp_v[7]);
            chk("m_done",     done,     exp_v[6]);
            chk("m_shift_en", shift_en, exp_v[5]);
            chk("m_d_out",    d_out,    exp_v[4]);
            chk("m_bit_cnt",  bit_cnt,  exp_v[3:0]);
        end
    end

    // Present a word at a negedge; returns at the negedge of cycle 1.
    task automatic start_load(input logic [7:0] data, input logic ab);
        in_valid  = 1'b1;
        load_data = data;
        abort     = ab;
        @(negedge clk);
        in_valid  = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        reset = 1'b0; in_valid = 1'b0; abort = 1'b0; load_data = 8'h00;
        in_valid0 = 1'b0; abort0 = 1'b0; load_data0 = 8'h00;
        chain = 8'h00; chain0 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bit_cnt", bit_cnt, 4'd0);
        chk("rst_shift_en", shift_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready0", in_ready0, 1'b1);
        chk("rst_busy0", busy0, 1'b0);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // reset dropped mid-shift at bit 3
        start_load(8'hF0, 1'b0);
        repeat (2) @(negedge clk);
        chk("t1_bit_cnt_pre", bit_cnt, 4'd3);
        #2 reset = 1'b0;
        #1;
        chk("t1_shift_en", shift_en, 1'b0);
        chk("t1_d_out", d_out, 1'b0);
        chk("t1_bit_cnt", bit_cnt, 4'd0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_done", done, 1'b0);
        chk("t1_in_ready", in_ready, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t1_in_ready_after", in_ready, 1'b1);

        // A5 with no abort
        pat = 8'hA5;
        start_load(pat, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) chk("t2_d_out", d_out, pat[8-k]);
            chk("t2_done", done, (k == 11));
            if (k == 11) chk("t2_chain", chain, 8'hA5);
            @(negedge clk);
        end

        // abort in cycle 4
        start_load(8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_busy", busy, 1'b0);
        chk("t3_bit_cnt", bit_cnt, 4'd0);
        chk("t3_shift_en", shift_en, 1'b0);
        chk("t3_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t3_no_done", done, 1'b0);
            @(negedge clk);
        end

        // in_valid held high across two words
        in_valid = 1'b1; load_data = 8'h3C;
        @(negedge clk);
        load_data = 8'hC3;
        for (int k = 1; k <= 10; k++) begin
            chk("t4_in_ready_low", in_ready, 1'b0);
            @(negedge clk);
        end
        chk("t4_done1", done, 1'b1);
        chk("t4_ready_at_done", in_ready, 1'b1);
        chk("t4_chain1", chain, 8'h3C);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_second_cnt", bit_cnt, 4'd1);
        chk("t4_second_busy", busy, 1'b1);
        chk("t4_second_bit", d_out, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4_done2", done, 1'b1);
        chk("t4_chain2", chain, 8'hC3);
        @(negedge clk);

        // abort together with in_valid in IDLE
        start_load(8'h96, 1'b1);
        chk("t6_busy", busy, 1'b1);
        chk("t6_bit_cnt", bit_cnt, 4'd1);
        chk("t6_d_out", d_out, 1'b1);
        repeat (10) @(negedge clk);
        chk("t6_done", done, 1'b1);
        chk("t6_chain", chain, 8'h96);
        @(negedge clk);

        // HOLD_CYCLES=0 instance, FF
        in_valid0 = 1'b1; load_data0 = 8'hFF;
        @(negedge clk);
        in_valid0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("t5_shift_en", shift_en0, (k <= 8));
            chk("t5_d_out", d_out0, (k <= 8));
            chk("t5_done", done0, (k == 9));
            chk("t5_bit_cnt", bit_cnt0, (k <= 8) ? k : 8);
            if (k == 9) chk("t5_chain", chain0, 8'hFF);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
